// File: rtl/seg7_count_display_if.sv
// ---------------------------------------------------------------------------
// seg7_count_display_if
//
// This interface bundles the counter-side inputs and the display-side outputs
// of the seven-segment display stage.
//
//   value [3:0] : counter value to display (unsigned 0..15)
//   dir         : count direction, 0 = up ('U'), 1 = down ('d')
//   en          : display enable, 0 = all anodes off
//   an    [3:0] : digit anodes, active-low, an[0] = rightmost digit
//   seg   [6:0] : segments {g,f,e,d,c,b,a}, active-low
//   dp          : decimal point, active-low
//
// Modports:
//   master : the side that supplies the counter value and reads the pins
//   slave  : the display driver
// ---------------------------------------------------------------------------
interface seg7_count_display_if;
    logic [3:0] value;
    logic       dir;
    logic       en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output value,
        output dir,
        output en,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  value,
        input  dir,
        input  en,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/seg7_count_display.sv
// ---------------------------------------------------------------------------
// seg7_count_display
//
// This block drives a 4-digit, common-anode, time-multiplexed seven-segment
// display from the 4-bit up/down counter.
//   digit 0 : ones of the value, in decimal
//   digit 1 : tens of the value ('1', or blank/'0' when the value is below 10)
//   digit 2 : always dark
//   digit 3 : direction letter, 'U' (up) or 'd' (down)
//
// The counter value and direction are snapshotted once per full scan, at the
// end of the digit 3 slot, so a frame never tears. At the start of each digit
// slot, the anodes stay off for BLANK_CYC cycles to suppress ghosting.
//
// Parameters:
//   REFRESH_DIV : clk cycles per digit slot (>= 2)
//   BLANK_CYC   : dark cycles at the start of each slot (0 .. REFRESH_DIV-1)
//   LZ_BLANK    : 1 = blank the tens digit below 10, 0 = show a leading '0'
//
// Ports:
//   clk : system clock
//   rst : synchronous reset, active-low
//   bus : seg7_count_display_if.slave (value/dir/en in, an/seg/dp out)
//
// The an and seg outputs are registered. They reflect the slot position, the
// digit index, the snapshot and en as they were one cycle earlier.
// ---------------------------------------------------------------------------
module seg7_count_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000,
    parameter int LZ_BLANK    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_count_display_if.slave  bus
);

    localparam int               CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Internal digit codes: 0..9 are decimal digits; the rest are symbols.
    localparam logic [3:0] CODE_U     = 4'd10;
    localparam logic [3:0] CODE_D     = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Active-low segment patterns {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            CODE_U:  pat = SEG_U;
            CODE_D:  pat = SEG_D;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       idx_q,      idx_d;
    logic [3:0]       snap_val_q, snap_val_d;
    logic             snap_dir_q, snap_dir_d;
    logic [3:0]       an_q,       an_d;
    logic [6:0]       seg_q,      seg_d;

    logic             tick;
    logic             blank_done;
    logic             tens;
    logic [3:0]       ones;
    logic [3:0]       digit_code;
    logic             digit_lit;

    // -----------------------------------------------------------------------
    // Slot timer, digit index, and once-per-scan snapshot
    // -----------------------------------------------------------------------
    always_comb begin
        tick       = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d = tick ? '0 : slot_cnt_q + CNT_W'(1);
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        snap_val_d = snap_val_q;
        snap_dir_d = snap_dir_q;
        // The capture happens at the very end of digit 3, so the new data
        // starts with the ones digit of the next scan.
        if (tick && (idx_q == 2'd3)) begin
            snap_val_d = bus.value;
            snap_dir_d = bus.dir;
        end
    end

    // When there is no blanking window, the comparison is always true.
    // This case is handled separately so that no unsigned ">= 0" compare
    // is built.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign blank_done = 1'b1;
        end else begin : g_blank
            assign blank_done = (slot_cnt_q >= CNT_W'(BLANK_CYC));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Decimal split and digit selection
    // -----------------------------------------------------------------------
    always_comb begin
        tens = (snap_val_q >= 4'd10);
        ones = tens ? (snap_val_q - 4'd10) : snap_val_q;

        digit_code = CODE_BLANK;
        case (idx_q)
            2'd0: digit_code = ones;
            2'd1: begin
                if (tens)
                    digit_code = 4'd1;
                else if (LZ_BLANK != 0)
                    digit_code = CODE_BLANK;
                else
                    digit_code = 4'd0;
            end
            2'd2: digit_code = CODE_BLANK;
            2'd3: digit_code = snap_dir_q ? CODE_D : CODE_U;
            default: digit_code = CODE_BLANK;
        endcase

        // seg carries the glyph even while blanked. Only the anode gates
        // whether the digit is visible.
        seg_d     = glyph(digit_code);
        digit_lit = bus.en && blank_done && (digit_code != CODE_BLANK);
    end

    // Each anode is one-hot decoded from the index. Digit 2 is never driven.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_anode
            if (gi == 2) begin : g_dark
                assign an_d[gi] = 1'b1;
            end else begin : g_live
                assign an_d[gi] = !(digit_lit && (idx_q == 2'(gi)));
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_cnt_q <= '0;
            idx_q      <= 2'd0;
            snap_val_q <= 4'd0;
            snap_dir_q <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= SEG_BLANK;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            snap_val_q <= snap_val_d;
            snap_dir_q <= snap_dir_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_seg7_count_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_count_display
//
// This bench runs two instances with REFRESH_DIV=4 and BLANK_CYC=1 (one with
// LZ_BLANK=1 and one with LZ_BLANK=0) from shared inputs. A behavioural
// model tracks time since reset as a single cycle count. From that count it
// derives the slot and digit positions with division and modulo. It splits
// the value with /10 and %10, and looks glyphs up in a table.
// ---------------------------------------------------------------------------
module tb_seg7_count_display;

    localparam int RD = 4;
    localparam int BC = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_count_display_if bus_lz ();
    seg7_count_display_if bus_z ();

    seg7_count_display #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .LZ_BLANK(1)) dut_lz (
        .clk (clk),
        .rst (rst),
        .bus (bus_lz.slave)
    );

    seg7_count_display #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .LZ_BLANK(0)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Model state
    int         m_t;      // cycles since reset release = DUT's current position
    int         m_val;
    int         m_dir;
    logic [6:0] glyph_tab [0:12];

    // Shared stimulus
    logic [3:0] in_val;
    logic       in_dir;
    logic       in_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic d, input logic e);
        in_val = v; in_dir = d; in_en = e;
        bus_lz.value = v; bus_lz.dir = d; bus_lz.en = e;
        bus_z.value  = v; bus_z.dir  = d; bus_z.en  = e;
    endtask

    // This function returns the pins expected one cycle after the model's
    // current position.
    function automatic void model_pins(input bit lz, output logic [3:0] an, output logic [6:0] seg);
        int pos, idx, g;
        pos = m_t % RD;
        idx = (m_t / RD) % 4;
        case (idx)
            0:       g = m_val % 10;
            1:       g = (m_val / 10 > 0) ? m_val / 10 : (lz ? 12 : 0);
            3:       g = m_dir ? 11 : 10;
            default: g = 12;
        endcase
        seg = glyph_tab[g];
        an  = 4'b1111;
        if (in_en && pos >= BC && g != 12 && idx != 2)
            an[idx] = 1'b0;
    endfunction

    // This task runs one clock cycle with the inputs currently driven, then
    // compares the DUT pins against the model.
    task automatic step();
        logic [3:0] e_an_lz, e_an_z;
        logic [6:0] e_seg_lz, e_seg_z;
        if (!rst) begin
            e_an_lz = 4'b1111; e_an_z = 4'b1111;
            e_seg_lz = 7'b1111111; e_seg_z = 7'b1111111;
            m_t = 0; m_val = 0; m_dir = 0;
        end else begin
            model_pins(1'b1, e_an_lz, e_seg_lz);
            model_pins(1'b0, e_an_z, e_seg_z);
            if ((m_t % RD) == RD - 1 && ((m_t / RD) % 4) == 3) begin
                m_val = in_val;
                m_dir = in_dir;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("an_lz",  32'(bus_lz.an),  32'(e_an_lz));
        check("seg_lz", 32'(bus_lz.seg), 32'(e_seg_lz));
        check("an_z",   32'(bus_z.an),   32'(e_an_z));
        check("seg_z",  32'(bus_z.seg),  32'(e_seg_z));
        check("dp",     32'(bus_lz.dp & bus_z.dp), 32'd1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // This task advances until the next step starts at digit slot i, cycle p.
    task automatic run_to(input int i, input int p);
        int reached;
        reached = 0;
        for (int k = 0; k < 64; k++) begin
            if (((m_t / RD) % 4) == i && (m_t % RD) == p) begin
                reached = 1;
                break;
            end
            step();
        end
        check("run_to_bound", 32'(reached), 32'd1);
    endtask

    initial begin
        glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
        glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
        glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
        glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
        glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
        glyph_tab[10] = 7'b1000001; glyph_tab[11] = 7'b0100001;
        glyph_tab[12] = 7'b1111111;
        m_t = 0; m_val = 0; m_dir = 0;

        // 1: reset, then the first scan shows "U  0"
        rst = 1'b0;
        drive(4'd0, 1'b0, 1'b1);
        @(negedge clk);
        run(3);
        rst = 1'b1;
        run(16);
        $display("[TB] reset + first scan done, cycle %0d", cyc);

        // 2: value 13 for two scans
        drive(4'd13, 1'b0, 1'b1);
        run(32);
        $display("[TB] value=13 two scans done, cycle %0d", cyc);

        // 3: mid-scan change 4->7, then a change landing on the idx 3 tick
        drive(4'd4, 1'b0, 1'b1);
        run_to(0, 0);
        run_to(1, 0);
        drive(4'd7, 1'b0, 1'b1);
        run(32);
        run_to(3, 3);
        drive(4'd2, 1'b0, 1'b1);
        run(8);
        $display("[TB] snapshot timing done, cycle %0d", cyc);

        // 4: down, value 9 on both leading-zero variants
        drive(4'd9, 1'b1, 1'b1);
        run(32);
        $display("[TB] dir=1 value=9 done, cycle %0d", cyc);

        // 5: en low for 6 cycles mid slot 0
        run_to(0, 1);
        drive(4'd9, 1'b1, 1'b0);
        run(6);
        drive(4'd9, 1'b1, 1'b1);
        run(16);
        $display("[TB] enable gap done, cycle %0d", cyc);

        // 6: one-cycle reset pulse during slot 3 with value 15
        drive(4'd15, 1'b0, 1'b1);
        run_to(3, 1);
        rst = 1'b0;
        run(1);
        rst = 1'b1;
        run(40);
        $display("[TB] mid-scan reset done, cycle %0d", cyc);

        // 7: random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] v;
            logic       d, e;
            v = in_val; d = in_dir; e = in_en;
            if ($urandom_range(0, 7) == 0)   v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0)  d = ~d;
            if ($urandom_range(0, 9) == 0)   e = ~e;
            drive(v, d, e);
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step();
        end
        rst = 1'b1;
        $display("[TB] random phase done, cycle %0d", cyc);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
